// File: rtl/ca_row_printer.sv
// Streams a captured cellular-automaton generation as ASCII text, MSB first, ending each row with CR LF.
// Optional CA_ROW_NUMBER_EN adds a "HH:" hex row-number prefix to every row.
module ca_row_printer #(
  parameter int          WIDTH    = 128,
  parameter logic [7:0]  ON_CHAR  = 8'h23,
  parameter logic [7:0]  OFF_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             gen_stb,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef CA_ROW_NUMBER_EN
  typedef enum logic [2:0] {IDLE, PREFIX, BITS, CR, LF} state_t;
  logic [7:0] row_num;
  logic [1:0] pre_idx;
`else
  typedef enum logic [1:0] {IDLE, BITS, CR, LF} state_t;
`endif

  state_t           state, state_next;
  logic [WIDTH-1:0] row;
  logic [IW-1:0]    bit_idx;
  logic             xfer;

  // Handshake: tx_valid/tx_data are decoded from registered state only, so they
  // hold steady until a transfer (tx_valid & tx_ready) moves the state on.
  assign xfer = tx_valid & tx_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef CA_ROW_NUMBER_EN
      IDLE:   if (gen_stb) state_next = PREFIX;
      PREFIX: if (xfer && pre_idx == 2'd2) state_next = BITS;
`else
      IDLE:   if (gen_stb) state_next = BITS;
`endif
      BITS:   if (xfer && bit_idx == '0) state_next = CR;
      CR:     if (xfer) state_next = LF;
      LF:     if (xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      bit_idx  <= '0;
      drop_cnt <= 8'h00;
`ifdef CA_ROW_NUMBER_EN
      row_num  <= 8'h00;
      pre_idx  <= 2'd0;
`endif
    end else begin
      if (state == IDLE && gen_stb) begin
        row     <= data;
        bit_idx <= IW'(WIDTH - 1);
`ifdef CA_ROW_NUMBER_EN
        pre_idx <= 2'd0;
`endif
      end
      if (state == BITS && xfer && bit_idx != '0)
        bit_idx <= bit_idx - 1'b1;
`ifdef CA_ROW_NUMBER_EN
      if (state == PREFIX && xfer)
        pre_idx <= pre_idx + 2'd1;
      if (state == LF && xfer)
        row_num <= row_num + 8'd1;
`endif
      // Any strobe outside IDLE is lost, including the LF transfer cycle.
      if (gen_stb && state != IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef CA_ROW_NUMBER_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction
`endif

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    case (state)
`ifdef CA_ROW_NUMBER_EN
      PREFIX: begin
        tx_valid = 1'b1;
        case (pre_idx)
          2'd0:    tx_data = hex_ascii(row_num[7:4]);
          2'd1:    tx_data = hex_ascii(row_num[3:0]);
          default: tx_data = 8'h3A;
        endcase
      end
`endif
      BITS: begin
        tx_valid = 1'b1;
        tx_data  = row[bit_idx] ? ON_CHAR : OFF_CHAR;
      end
      CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
      end
      LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_ca_row_printer.sv
// Directed bench for ca_row_printer at WIDTH=8; covers the CA_ROW_NUMBER_EN prefix when that macro is defined.
module tb_ca_row_printer;

  localparam int WIDTH = 8;
`ifdef CA_ROW_NUMBER_EN
  localparam int PRE = 3;
`else
  localparam int PRE = 0;
`endif
  localparam int NBYTES = WIDTH + 2 + PRE;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data;
  logic             gen_stb;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic [7:0]       drop_cnt;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_row_num;

  ca_row_printer #(.WIDTH(WIDTH), .ON_CHAR(8'h23), .OFF_CHAR(8'h20)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .gen_stb  (gen_stb),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic build_exp(input logic [WIDTH-1:0] d);
    exp_q.delete();
    if (PRE != 0) begin
      exp_q.push_back(hex_char(exp_row_num[7:4]));
      exp_q.push_back(hex_char(exp_row_num[3:0]));
      exp_q.push_back(8'h3A);
    end
    for (int i = WIDTH - 1; i >= 0; i--)
      exp_q.push_back(d[i] ? 8'h23 : 8'h20);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic do_reset();
    rst = 1'b1; gen_stb = 1'b0; tx_ready = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_row_num = 8'h00;
    @(negedge clk);
  endtask

  // Runs one full row; called at a negedge with the DUT idle.
  task automatic run_row(input logic [WIDTH-1:0] d, input int pct, input int stb_pulses,
                         input string name);
    int         cycles;
    int         pulses;
    logic       prev_hold;
    logic [7:0] prev_data;
    logic [7:0] e;
    build_exp(d);
    pulses = stb_pulses;
    data = d; gen_stb = 1'b1;
    @(negedge clk);
    gen_stb = 1'b0;
    data = ~d;
    tests++;
    if (tx_valid !== 1'b1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL %s latency: tx_valid=%b busy=%b, expected 1 1", name, tx_valid, busy);
    end
    cycles = 0; prev_hold = 1'b0; prev_data = 8'h00;
    while (exp_q.size() > 0 && cycles < 2000) begin
      if (prev_hold) begin
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          failed++;
          $display("FAIL %s stable: tx_valid=%b tx_data=%h, expected 1 %h", name, tx_valid, tx_data, prev_data);
        end
      end
      tx_ready = ($urandom_range(99) < pct);
      if (pulses > 0 && (cycles % 2) == 1) begin
        gen_stb = 1'b1; pulses--;
      end else begin
        gen_stb = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        e = exp_q.pop_front();
        tests++;
        if (tx_data !== e) begin
          failed++;
          $display("FAIL %s byte%0d: got %h, expected %h", name, NBYTES - exp_q.size() - 1, tx_data, e);
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      cycles++;
      @(negedge clk);
    end
    gen_stb = 1'b0; tx_ready = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s timeout: %0d bytes missing, expected 0", name, exp_q.size());
    end
    if (pct >= 100) begin
      tests++;
      if (cycles != NBYTES) begin
        failed++;
        $display("FAIL %s cycles: got %0d, expected %0d", name, cycles, NBYTES);
      end
    end
    tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL %s end: tx_valid=%b busy=%b, expected 0 0", name, tx_valid, busy);
    end
    exp_row_num = exp_row_num + 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_ready = 1'b1; data = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      gen_stb = (i == 0);
      @(negedge clk);
      tests++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'h00 || tx_data !== 8'h00) begin
        failed++;
        $display("FAIL reset%0d: valid=%b busy=%b drop=%h data=%h, expected 0 0 00 00",
                 i, tx_valid, busy, drop_cnt, tx_data);
      end
    end
    rst = 1'b0; gen_stb = 1'b0; tx_ready = 1'b0;
    exp_row_num = 8'h00;
    @(negedge clk);
    tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_after: valid=%b busy=%b, expected 0 0", tx_valid, busy);
    end
  endtask

  task automatic test_basic();
    run_row(8'b1000_0001, 100, 0, "basic");
    run_row(8'b0110_1100, 100, 0, "basic2");
  endtask

  task automatic test_back_to_back();
    run_row(8'hFF, 100, 0, "b2b_a");
    run_row(8'h00, 100, 0, "b2b_b");
  endtask

  task automatic test_backpressure();
    run_row(8'b1000_0001, 30, 0, "bp");
    run_row(8'b0101_1010, 30, 0, "bp2");
  endtask

  task automatic test_overrun();
    do_reset();
    run_row(8'b1000_0001, 100, 3, "ovr");
    tests++;
    if (drop_cnt !== 8'd3) begin
      failed++;
      $display("FAIL ovr_cnt: got %0d, expected 3", drop_cnt);
    end
    run_row(8'b1100_0011, 30, 2, "ovr_bp");
    tests++;
    if (drop_cnt !== 8'd5) begin
      failed++;
      $display("FAIL ovr_cnt2: got %0d, expected 5", drop_cnt);
    end
  endtask

  task automatic test_held_stb();
    do_reset();
    tx_ready = 1'b0; data = 8'hA5; gen_stb = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (drop_cnt !== 8'd3 || busy !== 1'b1) begin
      failed++;
      $display("FAIL held_stb: drop=%0d busy=%b, expected 3 1", drop_cnt, busy);
    end
    repeat (300) @(negedge clk);
    gen_stb = 1'b0;
    tests++;
    if (drop_cnt !== 8'hFF) begin
      failed++;
      $display("FAIL drop_sat: got %0d, expected 255", drop_cnt);
    end
    do_reset();
  endtask

  task automatic test_mid_reset();
    do_reset();
    data = 8'b1011_0010; gen_stb = 1'b1;
    @(negedge clk);
    gen_stb = 1'b0; tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_row_num = 8'h00;
    tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset: valid=%b busy=%b, expected 0 0", tx_valid, busy);
    end
    @(negedge clk);
    run_row(8'b1000_0000, 100, 0, "after_reset");
  endtask

`ifdef CA_ROW_NUMBER_EN
  task automatic test_row_number();
    do_reset();
    run_row(8'h81, 100, 0, "rownum0");
    while (exp_row_num != 8'h1F) run_row(8'(exp_row_num), 100, 0, "rownum");
    run_row(8'h3C, 100, 0, "rownum1F");
    while (exp_row_num != 8'h00) run_row(8'(exp_row_num), 100, 0, "rownum");
    run_row(8'hC3, 100, 0, "rownum_wrap");
  endtask
`endif

  initial begin
    rst = 1'b1; gen_stb = 1'b0; tx_ready = 1'b0; data = '0;
    exp_row_num = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_overrun();
    test_held_stb();
    test_mid_reset();
`ifdef CA_ROW_NUMBER_EN
    test_row_number();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
